// File: rtl/sigmoid_pkg.sv
// Shared constants for the piecewise-linear sigmoid/tanh pipeline.
// Breakpoints and intercepts are kept in small fixed formats and widened at use.
// Latency and handshake rules live in sigmoid_pipe; this file holds no logic.
package sigmoid_pkg;

    // Pipeline depth from input transfer to out_valid
    localparam int LAT = 3;

    // Internal magnitude format is Q4.(OUT_W+GUARD_W)
    localparam int INT_W   = 4;
    localparam int GUARD_W = 6;

    // Segment breakpoints 5.0, 2.375 and 1.0 as Q4.3
    localparam int         BP_Q4_FRAC = 3;
    localparam logic [6:0] BP_SAT_Q4  = 7'd40;
    localparam logic [6:0] BP_MID_Q4  = 7'd19;
    localparam logic [6:0] BP_LOW_Q4  = 7'd8;

    // Segment intercepts 0.84375, 0.625 and 0.5 as Q1.5
    localparam int         ICPT_FRAC  = 5;
    localparam logic [5:0] ICPT_HI_Q  = 6'd27;
    localparam logic [5:0] ICPT_MID_Q = 6'd20;
    localparam logic [5:0] ICPT_LO_Q  = 6'd16;

    // Segment slopes 1/32, 1/8 and 1/4 as right shifts
    localparam int SH_HI  = 5;
    localparam int SH_MID = 3;
    localparam int SH_LO  = 2;

    typedef enum logic {
        MODE_SIG  = 1'b0,
        MODE_TANH = 1'b1
    } mode_e;

    // Internal fraction width for a given output fraction width
    function automatic int frac_w(input int out_w);
        return out_w + GUARD_W;
    endfunction

endpackage

// File: rtl/fp32_to_fix.sv
// IEEE-754 single to sign + saturated |x| in Q4.F, plus NaN flag (SIGMOID_TANH_EN adds x2 for tanh).
// Latency: purely combinational; the caller registers the result.
// Backpressure: none, no state.
module fp32_to_fix
    import sigmoid_pkg::*;
#(
    parameter int F = 22
) (
    input  logic [31:0]  x_i,
    input  logic         dbl_i,
    output logic         sign_o,
    output logic [F+3:0] mag_o,
    output logic         nan_o
);

    localparam int XW = INT_W + F;
    localparam int TW = 24 + F;
    localparam logic [XW-1:0] MAG_SAT = XW'(8) << F;

    logic [7:0]    exp_raw;
    logic [22:0]   mant;
    logic [8:0]    exp_eff;
    logic [8:0]    rsh;
    logic [TW-1:0] sig_ext;

    assign exp_raw = x_i[30:23];
    assign mant    = x_i[22:0];

    // Unpack: zero/denormal -> 0, Inf or |x| >= 8 -> 8, otherwise truncating shift
    always_comb begin
        exp_eff = {1'b0, exp_raw};
`ifdef SIGMOID_TANH_EN
        if (dbl_i && (exp_raw != 8'h00) && (exp_raw != 8'hFF)) begin
            exp_eff = exp_eff + 9'd1;
        end
`endif
        // {1.mant} * 2^F, so value * 2^F = sig_ext >> (150 - exp)
        sig_ext = {1'b1, mant, {F{1'b0}}};
        rsh     = 9'd150 - exp_eff;
        nan_o   = (exp_raw == 8'hFF) && (mant != 23'd0);
        mag_o   = '0;
        if (exp_raw == 8'hFF) begin
            mag_o = nan_o ? '0 : MAG_SAT;
        end else if (exp_raw == 8'h00) begin
            mag_o = '0;
        end else if (exp_eff >= 9'd130) begin
            mag_o = MAG_SAT;
        end else begin
            mag_o = XW'(sig_ext >> rsh);
        end
        // A zero magnitude carries no sign, so -0 behaves exactly like +0
        sign_o = x_i[31] && (mag_o != '0);
    end

`ifndef SIGMOID_TANH_EN
    // The doubling request has no effect in a sigmoid-only build
    logic unused_dbl;
    assign unused_dbl = dbl_i;
`endif

endmodule

// File: rtl/sigmoid_pipe.sv
// Piecewise-linear sigmoid (tanh when SIGMOID_TANH_EN is defined) from fp32 to Q1.OUT_W.
// Latency: 3 cycles input transfer to out_valid; 1 result/cycle when unstalled.
// Backpressure: each stage advances when empty or when the next advances; in_ready follows out_ready combinationally.
module sigmoid_pipe
    import sigmoid_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_x,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT_W:0] out_y,
    output logic           out_nan
);

    localparam int F    = frac_w(OUT_W);
    localparam int XW   = INT_W + F;
    localparam int RW   = XW + 2;
    localparam int DROP = F - OUT_W;

    localparam logic [XW-1:0] ONE      = XW'(1) << F;
    localparam logic [XW-1:0] BP_SAT   = XW'(BP_SAT_Q4) << (F - BP_Q4_FRAC);
    localparam logic [XW-1:0] BP_MID   = XW'(BP_MID_Q4) << (F - BP_Q4_FRAC);
    localparam logic [XW-1:0] BP_LOW   = XW'(BP_LOW_Q4) << (F - BP_Q4_FRAC);
    localparam logic [XW-1:0] ICPT_HI  = XW'(ICPT_HI_Q)  << (F - ICPT_FRAC);
    localparam logic [XW-1:0] ICPT_MID = XW'(ICPT_MID_Q) << (F - ICPT_FRAC);
    localparam logic [XW-1:0] ICPT_LO  = XW'(ICPT_LO_Q)  << (F - ICPT_FRAC);

    localparam logic signed [RW-1:0] RND   = RW'(1) << (DROP - 1);
    localparam logic signed [RW-1:0] Y_MAX = RW'((1 << OUT_W) - 1);
    localparam logic [OUT_W:0]       Y_NAN_SIG = (OUT_W+1)'(1) << (OUT_W - 1);

    // Stage occupancy and advance enables
    logic s1_vld_q, s2_vld_q, out_valid_q;
    logic adv1, adv2, adv3;

    assign adv3      = !out_valid_q || out_ready;
    assign adv2      = !s2_vld_q || adv3;
    assign adv1      = !s1_vld_q || adv2;
    assign in_ready  = adv1 || rst;
    assign out_valid = out_valid_q;

    // S1 unpack
    logic          sign_d, nan_d;
    logic [XW-1:0] mag_d;
    mode_e         mode_d;

`ifdef SIGMOID_TANH_EN
    assign mode_d = mode_e'(in_mode);
`else
    // Every transaction is sigmoid; in_mode has no effect
    assign mode_d = MODE_SIG;
    logic unused_mode;
    assign unused_mode = in_mode;
`endif

    fp32_to_fix #(.F(F)) u_unpack (
        .x_i    (in_x),
        .dbl_i  (mode_d == MODE_TANH),
        .sign_o (sign_d),
        .mag_o  (mag_d),
        .nan_o  (nan_d)
    );

    logic          s1_sign_q, s1_nan_q;
    logic [XW-1:0] s1_mag_q;
    logic          s2_sign_q, s2_nan_q;
    logic [XW-1:0] s2_sp_q;
`ifdef SIGMOID_TANH_EN
    mode_e         s1_mode_q, s2_mode_q;
`endif

    // S2 segment select: sigma(|x|) with shift-only slopes
    logic [XW-1:0] sp_d;
    always_comb begin
        if (s1_mag_q >= BP_SAT) begin
            sp_d = ONE;
        end else if (s1_mag_q >= BP_MID) begin
            sp_d = (s1_mag_q >> SH_HI) + ICPT_HI;
        end else if (s1_mag_q >= BP_LOW) begin
            sp_d = (s1_mag_q >> SH_MID) + ICPT_MID;
        end else begin
            sp_d = (s1_mag_q >> SH_LO) + ICPT_LO;
        end
    end

    // S3 symmetry, optional 2*sigma-1, round half-up, clamp, NaN override
    logic [XW-1:0]        sigma;
    logic signed [RW-1:0] t_full, r_full;
    logic [OUT_W:0]       y_d;
    always_comb begin
        sigma  = s2_sign_q ? (ONE - s2_sp_q) : s2_sp_q;
        t_full = RW'(sigma);
`ifdef SIGMOID_TANH_EN
        if (s2_mode_q == MODE_TANH) begin
            t_full = (RW'(sigma) <<< 1) - RW'(ONE);
        end
`endif
        r_full = (t_full + RND) >>> DROP;
        if (r_full > Y_MAX) begin
            r_full = Y_MAX;
        end else if (r_full < -Y_MAX) begin
            r_full = -Y_MAX;
        end
        y_d = (OUT_W+1)'(r_full);
        if (s2_nan_q) begin
`ifdef SIGMOID_TANH_EN
            y_d = (s2_mode_q == MODE_TANH) ? '0 : Y_NAN_SIG;
`else
            y_d = Y_NAN_SIG;
`endif
        end
    end

    // S1 register: capture the unpacked operand whenever the stage can move
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
        end else if (adv1) begin
            s1_vld_q  <= in_valid;
            s1_sign_q <= sign_d;
            s1_mag_q  <= mag_d;
            s1_nan_q  <= nan_d;
`ifdef SIGMOID_TANH_EN
            s1_mode_q <= mode_d;
`endif
        end
    end

    // S2 register: segment result travels with sign, NaN flag and mode
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
        end else if (adv2) begin
            s2_vld_q  <= s1_vld_q;
            s2_sign_q <= s1_sign_q;
            s2_sp_q   <= sp_d;
            s2_nan_q  <= s1_nan_q;
`ifdef SIGMOID_TANH_EN
            s2_mode_q <= s1_mode_q;
`endif
        end
    end

    // S3 output register: holds steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_y       <= '0;
            out_nan     <= 1'b0;
        end else if (adv3) begin
            out_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_y   <= y_d;
                out_nan <= s2_nan_q;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed and random stimulus for sigmoid_pipe with an in-order expectation queue.
module tb_sigmoid_pipe;

    localparam int OUT_W   = 16;
    localparam int LAT_EXP = 3;
`ifdef SIGMOID_TANH_EN
    localparam bit TANH_EN = 1'b1;
`else
    localparam bit TANH_EN = 1'b0;
`endif

    typedef logic [OUT_W:0] y_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_mode;
    logic        out_valid, out_ready, out_nan;
    logic [31:0] in_x;
    y_t          out_y;

    always #5 clk = ~clk;

    sigmoid_pipe #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_nan   (out_nan)
    );

    typedef struct packed {
        y_t   y;
        logic nan;
        logic tol;
        logic lat;
        int   acc_cyc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   acc;

    logic [31:0] bp_x [5] = '{32'h3FC00000, 32'hBFC00000, 32'h3F000000, 32'h40400000, 32'h00000000};
    int          bp_y [5] = '{53248, 12288, 40960, 61440, 32768};

    // Independent real-valued model of the transfer function
    function automatic y_t ref_y(input logic [31:0] x, input logic m);
        real a, s, v, r;
        int  e, yi;
        bit  th;
        th = TANH_EN && m;
        e  = int'(x[30:23]);
        if (e == 0)        a = 0.0;
        else if (e == 255) a = 8.0;
        else               a = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        if (th) a = a * 2.0;
        if (a >= 5.0)        s = 1.0;
        else if (a >= 2.375) s = a / 32.0 + 0.84375;
        else if (a >= 1.0)   s = a / 8.0 + 0.625;
        else                 s = a / 4.0 + 0.5;
        if (x[31]) s = 1.0 - s;
        v = th ? (2.0 * s - 1.0) * 65536.0 : s * 65536.0;
        r = $floor(v + 0.5);
        if (r > 65535.0)  r = 65535.0;
        if (r < -65535.0) r = -65535.0;
        yi = int'(r);
        return y_t'(yi);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        int   d;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_output: out_y=%0h with nothing pending", out_y);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (e.tol) begin
                d = int'($signed(out_y)) - int'($signed(e.y));
                assert (d >= -1 && d <= 1) else begin
                    errors++;
                    $error("FAIL rand_y: observed %0h required %0h (+-1)", out_y, e.y);
                end
            end else begin
                assert (out_y === e.y) else begin
                    errors++;
                    $error("FAIL out_y: observed %0h required %0h", out_y, e.y);
                end
            end
            checks++;
            assert (out_nan === e.nan) else begin
                errors++;
                $error("FAIL out_nan: observed %b required %b", out_nan, e.nan);
            end
            if (e.lat) begin
                checks++;
                assert (cyc - e.acc_cyc == LAT_EXP) else begin
                    errors++;
                    $error("FAIL latency: observed %0d required %0d", cyc - e.acc_cyc, LAT_EXP);
                end
            end
        end
    endtask

    // One clock: sample handshakes at negedge, settle #1 after posedge
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (out_valid === 1'b1 && out_ready && !rst) check_out();
        if (acc) begin
            cur.acc_cyc = cyc;
            q.push_back(cur);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [31:0] x, input logic m, input int yv,
                        input logic nan, input logic tol, input logic lat);
        in_x     = x;
        in_mode  = m;
        in_valid = 1'b1;
        cur.y    = y_t'(yv);
        cur.nan  = nan;
        cur.tol  = tol;
        cur.lat  = lat;
    endtask

    task automatic send(input logic [31:0] x, input logic m, input int yv,
                        input logic nan, input logic tol, input logic lat, input bit rnd);
        load(x, m, yv, nan, tol, lat);
        acc = 1'b0;
        for (int k = 0; k < 64 && !acc; k++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept_timeout: in_ready=%b required an accept", in_ready);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() > 0; k++) tick();
        chk("drain_pending", q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        int          idx, n_acc;
        y_t          held;
        logic [31:0] rx;
        logic        rm;

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;
        cur = '0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_nan", out_nan, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Sigmoid sweep, back-to-back, first result 3 cycles after accept
        send(32'hC0E00000, 1'b0, 0,     1'b0, 1'b0, 1'b1, 1'b0);
        send(32'hBFC00000, 1'b0, 12288, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h00000000, 1'b0, 32768, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h3F000000, 1'b0, 40960, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h3FC00000, 1'b0, 53248, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h40400000, 1'b0, 61440, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h40E00000, 1'b0, 65535, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Special operands
        send(32'h7F800000, 1'b0, 65535, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'hFF800000, 1'b0, 0,     1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h80000000, 1'b0, 32768, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h7FC00000, 1'b0, 32768, 1'b1, 1'b0, 1'b1, 1'b0);
        send(32'h00000001, 1'b0, 32768, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

`ifdef SIGMOID_TANH_EN
        // Tanh interleaved with sigmoid to exercise per-operand mode tagging
        send(32'h3F000000, 1'b1, 32768,  1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h00000000, 1'b0, 32768,  1'b0, 1'b0, 1'b1, 1'b0);
        send(32'hBF000000, 1'b1, -32768, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h00000000, 1'b0, 32768,  1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h00000000, 1'b1, 0,      1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h40E00000, 1'b1, 65535,  1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h7FC00000, 1'b1, 0,      1'b1, 1'b0, 1'b1, 1'b0);
`else
        // Sigmoid-only build: in_mode must be ignored
        send(32'h3F000000, 1'b1, 40960, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'hBF000000, 1'b1, 24576, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'h7FC00000, 1'b1, 32768, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        drain();

        // Backpressure: 5 offered, 3 accepted, output frozen, then all 5 in order
        out_ready = 1'b0;
        idx = 0;
        n_acc = 0;
        load(bp_x[0], 1'b0, bp_y[0], 1'b0, 1'b0, 1'b0);
        repeat (6) begin
            tick();
            if (acc) begin
                n_acc++;
                idx++;
                if (idx < 5) load(bp_x[idx], 1'b0, bp_y[idx], 1'b0, 1'b0, 1'b0);
                else in_valid = 1'b0;
            end
        end
        chk("bp_accepts", n_acc, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head_y", out_y, 32'(bp_y[0]));
        held = out_y;
        tick();
        tick();
        chk("bp_hold_y", out_y, held);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && idx < 5; k++) begin
            tick();
            if (acc) begin
                idx++;
                if (idx < 5) load(bp_x[idx], 1'b0, bp_y[idx], 1'b0, 1'b0, 1'b0);
                else in_valid = 1'b0;
            end
        end
        chk("bp_all_accepted", idx, 5);
        drain();

        // Reset with two operands in flight
        send(32'h3F000000, 1'b0, 40960, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'h3FC00000, 1'b0, 53248, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_y", out_y, 0);
        chk("mid_rst_out_nan", out_nan, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        rst = 1'b0;
        send(32'h00000000, 1'b0, 32768, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Random floats with random consumer stalls
        for (int i = 0; i < 150; i++) begin
            rx = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 131)), 23'($urandom)};
            rm = 1'($urandom_range(0, 1));
            send(rx, rm, int'($signed(ref_y(rx, rm))), 1'b0, 1'b1, 1'b0, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
